// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes and FSM states.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_t;

    // Signed variants sign-extend (MULT) or take magnitudes (DIV).
    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, WIDTH cycles.
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_b;
    logic [CntW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
    always_comb begin
        w_shift = {r_rem, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_b};
        o_last  = r_busy && (r_cnt == CntW'(WIDTH - 1));
    end

    // Iteration state; a negative trial difference restores the shifted remainder.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q     <= '0;
            r_rem   <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_abort) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_q     <= i_a;
            r_rem   <= '0;
            r_b     <= i_b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else if (r_busy) begin
            r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_cnt <= r_cnt + CntW'(1);
            if (o_last) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;
    assign o_r     = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  mdu_op_t          req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [CntW-1:0]    r_mul_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_div_a;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;

    logic               w_accept;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic               w_mul_last;
    logic               w_mt_write;
    logic               w_mul_write;
    logic               w_fix_write;
    logic               w_div_start;
    logic               w_div_last;
    logic               w_div_valid;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Operand conditioning: 2*WIDTH extension for the product, magnitudes for the divider.
    always_comb begin
        w_is_signed = op_is_signed(req_op);
        w_a_neg     = w_is_signed & req_a[WIDTH-1];
        w_b_neg     = w_is_signed & req_b[WIDTH-1];
        w_mul_a     = {{WIDTH{w_a_neg}}, req_a};
        w_mul_b     = {{WIDTH{w_b_neg}}, req_b};
        w_abs_a     = w_a_neg ? -req_a : req_a;
        w_abs_b     = w_b_neg ? -req_b : req_b;
        w_q_fix     = r_neg_q ? -w_div_q : w_div_q;
        w_r_fix     = r_neg_r ? -w_div_r : w_div_r;
        w_mul_last  = (r_mul_cnt == CntW'(MUL_STAGES - 1));
        w_accept    = req_valid && req_ready && !flush;
        w_div_start = w_accept && ((req_op == MD_DIV) || (req_op == MD_DIVU));
    end

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_div_start),
        .i_abort (flush),
        .i_a     (w_abs_a),
        .i_b     (w_abs_b),
        .o_last  (w_div_last),
        .o_valid (w_div_valid),
        .o_q     (w_div_q),
        .o_r     (w_div_r)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; flush from any busy state returns to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && ((req_op == MD_MULT) || (req_op == MD_MULTU))) begin
                    w_state_next = S_MUL;
                end else if (w_div_start) begin
                    w_state_next = S_DIV;
                end
            end
            S_MUL: begin
                if (flush || w_mul_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (w_div_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs and HI/LO write strobes; flush suppresses any pending write.
    always_comb begin
        req_ready   = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        w_mt_write  = w_accept && ((req_op == MD_MTHI) || (req_op == MD_MTLO));
        w_mul_write = (r_state == S_MUL) && w_mul_last && !flush;
        w_fix_write = (r_state == S_FIX) && w_div_valid && !flush;
    end

    // Operand/result capture, HI/LO update and the registered done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mul_cnt <= '0;
            r_prod    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_div_a   <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_mt_write | w_mul_write | w_fix_write;
            if (w_accept) begin
                r_mul_cnt <= '0;
                r_prod    <= w_mul_a * w_mul_b;
                r_div_a   <= req_a;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_div0    <= (req_b == '0);
            end else if (r_state == S_MUL) begin
                r_mul_cnt <= r_mul_cnt + CntW'(1);
            end
            if (w_mt_write) begin
                if (req_op == MD_MTHI) begin
                    r_hi <= req_a;
                end else begin
                    r_lo <= req_a;
                end
            end else if (w_mul_write) begin
                {r_hi, r_lo} <= r_prod;
            end else if (w_fix_write) begin
                // Divide by zero leaves the raw dividend in HI, all ones in LO.
                if (r_div0) begin
                    r_hi <= r_div_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_r_fix;
                    r_lo <= w_q_fix;
                end
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32, MUL_STAGES=3).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    mdu_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(
        .WIDTH      (32),
        .MUL_STAGES (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then scramble the operand inputs.
    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        req_a     = 32'hA5A5_A5A5;
        req_b     = 32'h5A5A_5A5A;
    endtask

    // Edges from the current sample point until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_mult();
        int cyc;
        issue(MD_MULT, 32'hFFFF_FFFF, 32'h2);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++; $display("FAIL mult_busy_c%0d: got %b want 10", c, {busy, done});
            end
            step();
        end
        checks++;
        if ({done, busy, hi, lo} !== {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL mult_result: got done=%b busy=%b %h_%h want 1 0 ffffffff_fffffffe",
                     done, busy, hi, lo);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL mult_done_pulse: got %b want 0", done);
        end
        // -3 * -5 = 15
        issue(MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        wait_done(cyc);
        checks++;
        if (cyc !== 3 || {hi, lo} !== 64'h0000_0000_0000_000F) begin
            errors++; $display("FAIL mult_negneg: got cyc=%0d %h_%h want 3 0_f", cyc, hi, lo);
        end
        step();
    endtask

    task automatic test_multu();
        int nbusy = 0;
        int ndone = 0;
        logic [63:0] got = '0;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
        for (int c = 0; c < 8; c++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                got = {hi, lo};
            end
            step();
        end
        checks++;
        if (nbusy !== 3) begin
            errors++; $display("FAIL multu_busy_cycles: got %0d want 3", nbusy);
        end
        checks++;
        if (ndone !== 1 || got !== 64'h0000_0001_FFFF_FFFE) begin
            errors++; $display("FAIL multu_result: got done=%0d %h want 1 00000001fffffffe",
                               ndone, got);
        end
        // 2^31 * 2^31 = 2^62, no sign extension
        issue(MD_MULTU, 32'h8000_0000, 32'h8000_0000);
        for (int c = 0; c < 3; c++) step();
        checks++;
        if ({done, hi, lo} !== {1'b1, 32'h4000_0000, 32'h0}) begin
            errors++; $display("FAIL multu_big: got done=%b %h_%h want 1 40000000_0", done, hi, lo);
        end
        step();
    endtask

    task automatic test_div();
        int early = 0;
        int cyc;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
        for (int c = 0; c < 32; c++) begin
            if (done) early++;
            step();
        end
        checks++;
        if (early !== 0 || {busy, done} !== 2'b10 || {hi, lo} !== {32'h4000_0000, 32'h0}) begin
            errors++;
            $display("FAIL div_pending: got early=%0d busy=%b done=%b %h_%h want 0 1 0 40000000_0",
                     early, busy, done, hi, lo);
        end
        step();
        checks++;
        if ({done, busy, hi, lo} !== {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++;
            $display("FAIL div_neg7_2: got done=%b busy=%b %h_%h want 1 0 ffffffff_fffffffd",
                     done, busy, hi, lo);
        end
        step();
        issue(MD_DIVU, 32'h7, 32'h0);
        wait_done(cyc);
        checks++;
        if (cyc !== 33 || {hi, lo} !== {32'h7, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL divu_by0: got cyc=%0d %h_%h want 33 7_ffffffff", cyc, hi, lo);
        end
        step();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h0);
        wait_done(cyc);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL div_by0: got %h_%h want fffffff9_ffffffff", hi, lo);
        end
        step();
        issue(MD_DIV, 32'h7, 32'hFFFF_FFFE);
        wait_done(cyc);
        checks++;
        if ({hi, lo} !== {32'h1, 32'hFFFF_FFFD}) begin
            errors++; $display("FAIL div_7_neg2: got %h_%h want 1_fffffffd", hi, lo);
        end
        step();
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_100_7: got %h_%h want 2_e", hi, lo);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        checks++;
        if (cyc !== 33 || {hi, lo} !== {32'h0, 32'h8000_0000}) begin
            errors++; $display("FAIL div_overflow: got cyc=%0d %h_%h want 33 0_80000000",
                               cyc, hi, lo);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b want 1", req_ready);
        end
        issue(MD_MTLO, 32'h1234, 32'h0);
        checks++;
        if ({done, busy, hi, lo} !== {2'b10, 32'h0, 32'h1234}) begin
            errors++; $display("FAIL b2b_mtlo: got done=%b busy=%b %h_%h want 1 0 0_1234",
                               done, busy, hi, lo);
        end
        issue(MD_MTHI, 32'hCAFE_F00D, 32'h0);
        checks++;
        if ({done, busy, hi, lo} !== {2'b10, 32'hCAFE_F00D, 32'h1234}) begin
            errors++; $display("FAIL b2b_mthi: got done=%b busy=%b %h_%h want 1 0 cafef00d_1234",
                               done, busy, hi, lo);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL mt_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_flush();
        int ndone = 0;
        issue(MD_DIVU, 32'd1000, 32'd3);
        for (int c = 0; c < 9; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || {hi, lo} !== {32'hCAFE_F00D, 32'h1234}) begin
            errors++; $display("FAIL flush_div: got busy=%b done=%b %h_%h want 0 0 cafef00d_1234",
                               busy, done, hi, lo);
        end
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            step();
        end
        checks++;
        if (ndone !== 0 || {hi, lo} !== {32'hCAFE_F00D, 32'h1234}) begin
            errors++; $display("FAIL flush_nodone: got done=%0d %h_%h want 0 cafef00d_1234",
                               ndone, hi, lo);
        end
        // Flush during the S_FIX cycle beats the write.
        issue(MD_DIVU, 32'd9, 32'd2);
        for (int c = 0; c < 32; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || {hi, lo} !== {32'hCAFE_F00D, 32'h1234}) begin
            errors++; $display("FAIL flush_fix: got busy=%b done=%b %h_%h want 0 0 cafef00d_1234",
                               busy, done, hi, lo);
        end
        // Flush with a request in idle drops it.
        flush = 1'b1;
        issue(MD_MTHI, 32'h1111_1111, 32'h0);
        flush = 1'b0;
        checks++;
        if (done !== 1'b0 || hi !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL flush_idle: got done=%b hi=%h want 0 cafef00d", done, hi);
        end
    endtask

    task automatic test_reset_mid();
        issue(MD_MULT, 32'h3, 32'h5);
        step();
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b %h_%h want 0 0 0_0",
                               busy, done, hi, lo);
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_mid_ready: got ready=%b busy=%b want 1 0",
                               req_ready, busy);
        end
        step();
        step();
        checks++;
        if ({done, hi, lo} !== 65'h0) begin
            errors++; $display("FAIL reset_mid_nowrite: got done=%b %h_%h want 0 0_0", done, hi, lo);
        end
        issue(MD_MTLO, 32'h55, 32'h0);
        checks++;
        if ({done, lo} !== {1'b1, 32'h55}) begin
            errors++; $display("FAIL reset_mid_mtlo: got done=%b lo=%h want 1 55", done, lo);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_op    = MD_MULT;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        resetn    = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
